cla_nibble_sequencer: RTL and testbench
=======================================

# cla_nibble_sequencer

Multi-cycle adder controller that sequences a single internal 4-bit carry-look-ahead slice across a WIDTH-bit operand pair, one nibble per clock, least-significant nibble first. It registers the inter-nibble carry and assembles the full sum. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area wherever a full-width CLA is too large.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4, minimum 4
- NIB (derived, WIDTH/4), number of nibble steps per operation
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair and cin valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry into nibble 0
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- sum_o  output  WIDTH  A + B + cin, modulo 2^WIDTH
- cout_o  output  1  carry out of bit WIDTH-1
- ovf_o  output  1  signed overflow: carry into bit WIDTH-1 XOR cout_o
- busy_o  output  1  high in RUN

## Operation
- States: IDLE, RUN, DONE.
- Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, busy_o=0, sum_o=0, cout_o=0, ovf_o=0. All internal registers are cleared: A, B, carry, nibble index.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge, latch a_i, b_i and cin_i into the carry register, clear the index to 0 and clear the sum register, then go to RUN.
  - With in_valid low, stay in IDLE.
- RUN, each edge:
  - Slice inputs are x = A[4*idx+3:4*idx], y = B[...] and c0 = the carry register.
  - Slice equations: g=x&y, p=x^y, c[k+1]=g[k]|(p[k]&c[k]) for k=0..3, s=p^c[3:0]. These are computed in look-ahead form from g, p and c0 only, with no ripple through s.
  - Write s into sum[4*idx+3:4*idx], set carry=c[4], and idx+1.
  - On the step where idx=NIB-1, also latch cout_o=c[4] and ovf_o=c[3]^c[4], then go to DONE.
- DONE:
  - out_valid=1. sum_o, cout_o and ovf_o are held stable.
  - On out_ready at an edge, go to IDLE.
  - Without out_ready, stay; there is no timeout.
- in_valid is ignored outside IDLE; no operand is queued.
- out_ready is ignored outside DONE.
- Result outputs keep their last values in IDLE and RUN. The sum register is cleared on accept, so partially built sums are visible in RUN. Consumers use sum_o only while out_valid=1.
- Reset asserted in any state, including mid-RUN or in DONE, returns immediately to the reset values. The operation in flight is discarded and no result is produced.
- cin_i=1 with all-ones operands wraps correctly: sum = 2^WIDTH-1 plus carry.

## Timing
- Accept edge E0 is the edge with IDLE and in_valid=1.
- RUN occupies edges E1..ENIB. Nibble k is written at edge E(k+1).
- out_valid rises after edge ENIB, giving a latency of NIB cycles from accept (4 for WIDTH=16).
- The DONE→IDLE edge is the first edge with out_ready=1. in_ready rises after that edge, and the next accept is possible one edge later.
- Minimum initiation interval is NIB+2 cycles (6 for WIDTH=16), with out_ready held high.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset then idle: assert rst mid-cycle, asynchronously → outputs immediately reach their reset values, in_ready=1; hold in_valid=0 for 10 cycles → no state change.
- WIDTH=16, a=0x1234, b=0x4321, cin=1, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x5556, cout=0, ovf=0; in_ready back after 6 cycles.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Backpressure: a=0x8000, b=0x8000, cin=1, out_ready low 5 cycles in DONE → sum=0x0001, cout=1, ovf=1, all stable; in_ready=0 throughout; in_valid pulses during RUN/DONE are ignored.
- Reset mid-RUN: accept a=0xAAAA, b=0x5555, assert rst after 2 RUN edges → out_valid never rises; after release, a=0x0F0F, b=0x00F1 → sum=0x1000, cout=0.
- WIDTH=8 instance: a=0xAB, b=0x55, cin=0 → latency 2 cycles, sum=0x00, cout=1, ovf=0.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: multi-cycle adder that runs one 4-bit carry-look-ahead
// slice across a WIDTH-bit operand pair, least-significant nibble first.
// The inter-nibble carry is registered and the sum is assembled in place.
// Valid/ready handshakes are used on both the operand and the result side.
// WIDTH must be a multiple of 4 and at least 4.
module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    // Slice signals for the nibble currently selected by idx_q.
    logic [3:0]         x;
    logic [3:0]         y;
    logic [3:0]         g;
    logic [3:0]         p;
    logic [4:0]         c_d;
    logic [3:0]         sum_nib_d;

    // Look-ahead slice: every carry is a flat sum of products of g, p and c0,
    // so no carry depends on another carry or on a sum bit.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every pass,
        // so no latch is inferred.
        x   = a_q[4*idx_q +: 4];
        y   = b_q[4*idx_q +: 4];
        g   = x & y;
        p   = x ^ y;
        c_d[0] = carry_q;
        c_d[1] = g[0]
               | (p[0] & carry_q);
        c_d[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & carry_q);
        c_d[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & carry_q);
        c_d[4] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & carry_q);
        sum_nib_d = p ^ c_d[3:0];
    end

    // Sequencer FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the values from before this edge.
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        carry_q    <= cin_i;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[4*idx_q +: 4] <= sum_nib_d;
                    carry_q             <= c_d[4];
                    idx_q               <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        // Carry into the top bit is c_d[3] of the last nibble.
                        cout_q      <= c_d[4];
                        ovf_q       <= c_d[3] ^ c_d[4];
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy_o    = busy_q;
    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Testbench for cla_nibble_sequencer: a 16-bit and an 8-bit instance driven
// with directed and random operations, checked against plain integer addition.
module tb_cla_nibble_sequencer;

    logic        clk;
    logic        rst;

    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16;
    logic        cout16, ovf16, busy16;
    logic [15:0] a16, b16, sum16;

    logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8;
    logic        cout8, ovf8, busy8;
    logic [7:0]  a8, b8, sum8;

    int checks   = 0;
    int failures = 0;

    cla_nibble_sequencer #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a_i       (a16),
        .b_i       (b16),
        .cin_i     (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum_o     (sum16),
        .cout_o    (cout16),
        .ovf_o     (ovf16),
        .busy_o    (busy16)
    );

    cla_nibble_sequencer #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a_i       (a8),
        .b_i       (b8),
        .cin_i     (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum_o     (sum8),
        .cout_o    (cout8),
        .ovf_o     (ovf8),
        .busy_o    (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete 16-bit operation: accept, RUN with partial-sum checks,
    // optional backpressure in DONE, then release to IDLE.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int hold, input bit noise);
        logic [16:0] full;
        logic [15:0] sum_e;
        logic        cout_e;
        logic        ovf_e;
        logic [31:0] mask;
        int          cyc;
        full   = 17'(a) + 17'(b) + 17'(cin);
        sum_e  = full[15:0];
        cout_e = full[16];
        ovf_e  = (a[15] == b[15]) && (sum_e[15] != a[15]);

        check("idle_ready16", in_ready16, 1);
        in_valid16  = 1'b1;
        a16         = a;
        b16         = b;
        cin16       = cin;
        out_ready16 = (hold == 0);
        @(negedge clk);
        in_valid16 = 1'b0;
        check("accept_ready16", in_ready16, 0);
        check("accept_busy16", busy16, 1);
        check("accept_sum_clear16", sum16, 0);

        cyc = 0;
        while (out_valid16 !== 1'b1 && cyc < 20) begin
            if (noise) begin
                in_valid16 = 1'($urandom);
                a16        = 16'($urandom);
                b16        = 16'($urandom);
                cin16      = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (cyc <= 4) begin
                mask = (32'd1 << (4 * cyc)) - 32'd1;
                check("partial_sum16", sum16, 32'(sum_e) & mask);
                check("run_busy16", busy16, (cyc < 4) ? 1 : 0);
            end
        end
        in_valid16 = 1'b0;
        check("latency16", cyc, 4);
        check("done_valid16", out_valid16, 1);
        check("sum16", sum16, sum_e);
        check("cout16", cout16, cout_e);
        check("ovf16", ovf16, ovf_e);
        check("done_ready16", in_ready16, 0);

        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid16 = 1'($urandom);
                a16        = 16'($urandom);
                b16        = 16'($urandom);
            end
            @(negedge clk);
            check("hold_valid16", out_valid16, 1);
            check("hold_ready16", in_ready16, 0);
            check("hold_sum16", sum16, sum_e);
            check("hold_cout16", cout16, cout_e);
            check("hold_ovf16", ovf16, ovf_e);
        end
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("release_ready16", in_ready16, 1);
        check("release_valid16", out_valid16, 0);
        check("release_sum_kept16", sum16, sum_e);
        check("release_cout_kept16", cout16, cout_e);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] full;
        logic [7:0] sum_e;
        logic       ovf_e;
        int         cyc;
        full  = 9'(a) + 9'(b) + 9'(cin);
        sum_e = full[7:0];
        ovf_e = (a[7] == b[7]) && (sum_e[7] != a[7]);

        check("idle_ready8", in_ready8, 1);
        in_valid8  = 1'b1;
        a8         = a;
        b8         = b;
        cin8       = cin;
        out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        cyc = 0;
        while (out_valid8 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency8", cyc, 2);
        check("sum8", sum8, sum_e);
        check("cout8", cout8, full[8]);
        check("ovf8", ovf8, ovf_e);
        @(negedge clk);
        out_ready8 = 1'b0;
        check("release_ready8", in_ready8, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b0;
        in_valid8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; out_ready8  = 1'b0;

        // Power-on reset.
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_ready16", in_ready16, 1);
        check("rst_valid16", out_valid16, 0);
        check("rst_busy16", busy16, 0);
        check("rst_sum16", sum16, 0);
        check("rst_cout16", cout16, 0);
        check("rst_ovf16", ovf16, 0);
        check("rst_ready8", in_ready8, 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed operations.
        run16(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run16(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0);
        run16(16'h8000, 16'h8000, 1'b1, 5, 1'b1);

        // Asynchronous reset mid-cycle while result outputs hold non-zero values.
        #2 rst = 1'b1;
        #1;
        check("async_rst_sum16", sum16, 0);
        check("async_rst_cout16", cout16, 0);
        check("async_rst_ovf16", ovf16, 0);
        check("async_rst_ready16", in_ready16, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hold_ready16", in_ready16, 1);
            check("idle_hold_busy16", busy16, 0);
            check("idle_hold_valid16", out_valid16, 0);
        end

        // Reset after two RUN edges discards the operation.
        in_valid16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy16", busy16, 1);
        check("midrun_partial16", sum16, 16'h00FF);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_busy16", busy16, 0);
        check("midrun_rst_sum16", sum16, 0);
        check("midrun_rst_ready16", in_ready16, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrun_no_result16", out_valid16, 0);
        end
        run16(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

        // Random operations with random backpressure and input noise.
        for (int i = 0; i < 20; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        // 8-bit instance.
        run8(8'hAB, 8'h55, 1'b0);
        run8(8'h7F, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
